// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding RV32 load/store initiator for the peripheral bus
module mem_bus_master #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rd_strobe,
  output logic [3:0]  bus_wr_strobe,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic we;
  logic [2:0] f3;
  logic [1:0] lane;
  logic acc, bad;
  logic [7:0] rb;
  logic [15:0] rh;
  logic [31:0] ld;
  logic [3:0] mask;
  assign req_ready = state == IDLE && !rst;
  assign acc = req_valid && req_ready;
  assign bad = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
               (req_funct3 == 3'd2 && req_addr[1:0] != 2'd0) ||
               (req_we ? req_funct3 > 3'd2 : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11));
  assign mask = f3[1:0] == 2'd0 ? 4'b0001 << lane : f3[1:0] == 2'd1 ? 4'b0011 << lane : 4'b1111;
  assign bus_rd_strobe = state == ISSUE && !we;
  assign bus_wr_strobe = (state == ISSUE && we) ? mask : 4'b0000;
  assign resp_valid = state == RESP;
  // f3[2] marks the unsigned load variants
  assign rb = bus_rdata[{lane, 3'b000} +: 8];
  assign rh = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign ld = f3[1:0] == 2'd0 ? {{24{rb[7] & ~f3[2]}}, rb} :
              f3[1:0] == 2'd1 ? {{16{rh[15] & ~f3[2]}}, rh} : bus_rdata;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? (bad ? RESP : ISSUE) : IDLE;
      ISSUE:   state_n = we ? RESP : WAIT;
      WAIT:    state_n = cnt == 4'd0 ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      we <= 1'b0;
      f3 <= '0;
      lane <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      if (acc) begin
        we <= req_we;
        f3 <= req_funct3;
        lane <= req_addr[1:0];
      end
      if (acc && !bad) bus_addr <= {req_addr[31:2], 2'b00};
      if (acc && !bad && req_we)
        bus_wdata <= req_funct3[1:0] == 2'd0 ? {4{req_wdata[7:0]}} :
                     req_funct3[1:0] == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
      if (acc && bad) begin
        resp_rdata <= '0;
        resp_err <= 1'b1;
      end
      if (state == ISSUE) begin
        cnt <= 4'(RD_LATENCY - 1);
        if (we) begin
          resp_rdata <= '0;
          resp_err <= 1'b0;
        end
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) begin
          resp_rdata <= ld;
          resp_err <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
Initiator side of the core's memory-mapped peripheral bus (addr / wdata / rd_strobe / 4-bit wr_strobe / rdata). It accepts one RV32 load/store request at a time from the core's load-store stage. It then:
- issues a single word-aligned bus transaction with byte-lane strobes,
- waits a fixed read latency,
- returns aligned, sign- or zero-extended load data.

It sits between the core pipeline and the address decoder that fans out to the LED GPIO and other peripherals.

Parameters:
RD_LATENCY, 1, cycles from the bus_rd_strobe cycle to the cycle in which bus_rdata is valid (legal 1..15).

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  core request present
req_ready  out  1  block can accept a request
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32 width code (0 B, 1 H, 2 W, 4 BU, 5 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_err  out  1  misaligned or illegal request, valid with resp_valid
bus_addr  out  32  word address {req_addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_rd_strobe  out  1  one-cycle read pulse
bus_wr_strobe  out  4  one-cycle byte-enable pulse
bus_rdata  in  32  peripheral read data

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All outputs reset to 0; state resets to IDLE.
  - Asserting rst mid-transaction aborts it: no resp_valid is produced, and strobes drop on the next edge.
- States:
  - IDLE: req_ready=1 (0 while rst is high).
  - ISSUE: strobe cycle.
  - WAIT: latency counter running.
  - RESP: resp_valid=1.
- Accept: a request is accepted in cycle T when req_valid&req_ready. Its fields are captured into registers at that edge.
- Error check at accept. A request is an error if any of the following holds:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - a load with funct3 in {3,6,7};
  - a store with funct3>2.
  For an error: go to RESP directly, so resp_valid=1 and resp_err=1 in T+1 with resp_rdata=0. No bus strobe is issued.
- Store, cycle T+1 (ISSUE):
  - bus_addr = word address.
  - bus_wr_strobe = SB: 4'b0001<<addr[1:0]; SH: 4'b0011<<addr[1:0]; SW: 4'b1111.
  - bus_wdata = SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - T+2: RESP, resp_valid=1, resp_err=0, resp_rdata=0.
- Load, cycle T+1 (ISSUE): bus_rd_strobe=1 with bus_addr.
  - The WAIT counter loads RD_LATENCY-1.
  - bus_rdata is sampled on the edge ending cycle T+1+RD_LATENCY.
  - resp_valid is asserted in cycle T+2+RD_LATENCY.
  - When RD_LATENCY=1, WAIT lasts exactly one cycle.
- Load extraction, with byte lane = addr[1:0] and halfword select = addr[1]:
  - LB: sign-extend the selected byte.
  - LBU: zero-extend the selected byte.
  - LH/LHU: select the halfword, then sign- or zero-extend.
  - LW: pass through.
- Strobes are single-cycle pulses.
- bus_addr and bus_wdata hold their values until the next ISSUE.
- resp_rdata and resp_err hold their values until the next RESP.
- RESP always returns to IDLE. Back-to-back requests are therefore spaced with one IDLE cycle, during which req_ready=1.
- req_valid while not ready is ignored. The core must hold the request until it is accepted.
- bus_rdata is ignored outside the sample edge.

Test Plan:
- Reset, then SW addr 0x1000_0000, wdata 0x0000_00A5 → T+1: bus_addr 0x1000_0000, bus_wr_strobe 4'b1111, bus_wdata 0x0000_00A5; T+2: resp_valid=1, resp_err=0.
- SB addr 0x1000_0003, wdata 0x1234_5677 → bus_wr_strobe 4'b1000, bus_wdata 0x7777_7777, bus_addr 0x1000_0000.
- LB addr 0x1000_0002, bus_rdata returns 0x0080_0000, RD_LATENCY=1 → rd_strobe in T+1; resp_valid in T+3 with resp_rdata 0xFFFF_FF80. Repeating as LBU → 0x0000_0080.
- LH addr 0x1000_0001 → resp_valid T+1, resp_err=1, resp_rdata 0, no strobe ever asserted. Also check funct3=3 load → resp_err=1.
- RD_LATENCY=3, LW addr 0x1000_0000, bus_rdata 0xDEAD_BEEF valid in T+4 only → resp_valid T+5, resp_rdata 0xDEAD_BEEF, req_ready low T+1..T+5.
- Assert rst in the WAIT cycle of a load → no resp_valid afterwards, req_ready=0 during rst and 1 in the first cycle after rst deasserts; the following SW completes normally.
